// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, valid/ready data-bus sequencing and byte/half lane handling.
// Optional macro MEM_ALIGN_CHECK_EN traps misaligned half/word accesses without issuing a bus request.

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        validE,
    input  logic [31:0] aluOutE,
    input  logic [31:0] writeDataE,
    input  logic [4:0]  writeRegAddrE,
    input  logic        regWriteE,
    input  logic        memReadE,
    input  logic        memWriteE,
    input  logic [1:0]  memSizeE,
    input  logic        memSignE,
    output logic [31:0] aluOutM,
    output logic [4:0]  writeRegAddrM,
    output logic        regWriteM,
    output logic        validM,
    output logic        memToRegM,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        alignErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [31:0] writeDataM;
    logic [1:0]  memSizeM;
    logic        memSignM;
    logic        memWriteM;
    logic        regWriteHeldM;
    logic        memOpM;
    logic        misalignedM;
    logic        alignFaultM;

    function automatic logic [31:0] laneData(input logic [31:0] wd, input logic [1:0] size);
        case (size)
            2'b00:   laneData = {4{wd[7:0]}};
            2'b01:   laneData = {2{wd[15:0]}};
            default: laneData = wd;
        endcase
    endfunction

    function automatic logic [3:0] laneEnables(input logic [1:0] addrLo, input logic [1:0] size);
        case (size)
            2'b00:   laneEnables = 4'b0001 << addrLo;
            2'b01:   laneEnables = addrLo[1] ? 4'b1100 : 4'b0011;
            default: laneEnables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extractLoad(input logic [31:0] rdata, input logic [1:0] addrLo,
                                                input logic [1:0] size, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{addrLo, 3'b000} +: 8];
        h = addrLo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   extractLoad = {{24{sign & b[7]}}, b};
            2'b01:   extractLoad = {{16{sign & h[15]}}, h};
            default: extractLoad = rdata;
        endcase
    endfunction

    // M stage register and load-data capture; the whole stage clears on reset, dropping any open transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            validM        <= 1'b0;
            regWriteHeldM <= 1'b0;
            memToRegM     <= 1'b0;
            memWriteM     <= 1'b0;
            aluOutM       <= '0;
            writeDataM    <= '0;
            writeRegAddrM <= '0;
            memSizeM      <= '0;
            memSignM      <= 1'b0;
            readDataM     <= '0;
        end else begin
            state <= stateNext;
            if (!stallM) begin
                validM        <= validE;
                regWriteHeldM <= validE & regWriteE;
                memToRegM     <= validE & memReadE;
                memWriteM     <= validE & memWriteE;
                aluOutM       <= aluOutE;
                writeDataM    <= writeDataE;
                writeRegAddrM <= writeRegAddrE;
                memSizeM      <= memSizeE;
                memSignM      <= memSignE;
            end
            if (dmem_req && dmem_ready && !memWriteM) begin
                readDataM <= extractLoad(dmem_rdata, aluOutM[1:0], memSizeM, memSignM);
            end
        end
    end

    assign memOpM = validM & (memToRegM | memWriteM);

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (memSizeM)
            2'b00:   misalignedM = 1'b0;
            2'b01:   misalignedM = aluOutM[0];
            default: misalignedM = |aluOutM[1:0];
        endcase
    end
`else
    assign misalignedM = 1'b0;
`endif

    assign alignFaultM = memOpM & misalignedM;

    // stallM depends only on state and the held M register, keeping dmem_ready off the pipeline-stall path
    always_comb begin
        stateNext = state;
        stallM    = 1'b0;
        dmem_req  = 1'b0;
        case (state)
            IDLE: begin
                if (memOpM) begin
                    stallM = 1'b1;
                    if (alignFaultM) begin
                        stateNext = DONE;
                    end else begin
                        dmem_req  = 1'b1;
                        stateNext = dmem_ready ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                stallM   = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign regWriteM  = regWriteHeldM & ~alignFaultM;
    assign alignErrM  = (state == DONE) & alignFaultM;
    assign dmem_we    = memWriteM;
    assign dmem_addr  = {aluOutM[31:2], 2'b00};
    assign dmem_wdata = laneData(writeDataM, memSizeM);
    assign dmem_be    = memWriteM ? laneEnables(aluOutM[1:0], memSizeM) : 4'b1111;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-addressed reference memory, randomized bus latency,
// directed load/store cases and a reset-during-wait check.

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        validE;
    logic [31:0] aluOutE;
    logic [31:0] writeDataE;
    logic [4:0]  writeRegAddrE;
    logic        regWriteE;
    logic        memReadE;
    logic        memWriteE;
    logic [1:0]  memSizeE;
    logic        memSignE;
    logic [31:0] aluOutM;
    logic [4:0]  writeRegAddrM;
    logic        regWriteM;
    logic        validM;
    logic        memToRegM;
    logic [31:0] readDataM;
    logic        stallM;
    logic        alignErrM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .validE(validE), .aluOutE(aluOutE), .writeDataE(writeDataE),
        .writeRegAddrE(writeRegAddrE), .regWriteE(regWriteE), .memReadE(memReadE),
        .memWriteE(memWriteE), .memSizeE(memSizeE), .memSignE(memSignE),
        .aluOutM(aluOutM), .writeRegAddrM(writeRegAddrM), .regWriteM(regWriteM),
        .validM(validM), .memToRegM(memToRegM), .readDataM(readDataM), .stallM(stallM),
        .alignErrM(alignErrM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        bit          valid;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        bit          rw;
        bit          mr;
        bit          mw;
        logic [1:0]  sz;
        bit          sg;
    } instr_t;

    typedef struct {
        bit          full;
        bit          valid;
        bit          rw;
        bit          m2r;
        bit          alignErr;
        bit          isMem;
        bit          we;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        int          reqs;
    } exp_t;

    exp_t        sbQ[$];
    int          delayQ[$];
    logic [7:0]  modelMem [0:1023];
    logic [31:0] busMem [0:255];
    logic [31:0] lastRead = 32'h0;
    bit          monOn = 1'b0;
    bit          forceWait = 1'b0;
    int          nChecks = 0;
    int          nFails = 0;
    int          stallCnt = 0;
    int          reqCnt = 0;
    int          remaining = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isMisaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        return (a[0] & sz[0] & ~a[0]);
`endif
    endfunction

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic instr_t mk(input bit v, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [4:0] rd, input bit rw, input bit mr, input bit mw,
                                  input logic [1:0] sz, input bit sg);
        instr_t in;
        in.valid = v; in.alu = a; in.wd = wd; in.rd = rd; in.rw = rw;
        in.mr = mr; in.mw = mw; in.sz = sz; in.sg = sg;
        return in;
    endfunction

    function automatic instr_t randInstr();
        instr_t in;
        int k;
        k = int'($urandom_range(0, 9));
        in.valid = (k >= 2);
        if (k < 2) begin
            in.mr = 1'($urandom_range(0, 1));
            in.mw = !in.mr && 1'($urandom_range(0, 1));
        end else begin
            in.mr = (k >= 5 && k <= 7);
            in.mw = (k >= 8);
        end
        in.alu = (in.mr || in.mw) ? 32'($urandom_range(0, 1023)) : $urandom;
        in.wd  = $urandom;
        in.rd  = 5'($urandom_range(0, 31));
        in.rw  = 1'($urandom_range(0, 1));
        in.sz  = 2'($urandom_range(0, 3));
        in.sg  = 1'($urandom_range(0, 1));
        return in;
    endfunction

    // Reference model: what the M stage should present once this instruction has been captured
    task automatic modelCapture(input instr_t in, input int delay);
        exp_t        e;
        bit          mem;
        bit          bad;
        int          n;
        int          base;
        logic [31:0] v;
        logic [31:0] mask;
        mem  = in.valid && (in.mr || in.mw);
        bad  = mem && isMisaligned(in.alu, in.sz);
        n    = sizeBytes(in.sz);
        base = int'(in.alu[9:0]) & ~(n - 1);
        e.full = 1'b0;   e.valid = in.valid;  e.alu = in.alu;  e.rd = in.rd;
        e.rw = in.valid && in.rw && !bad;
        e.m2r = in.valid && in.mr;
        e.alignErr = bad;
        e.isMem = mem && !bad;
        e.we = in.mw;
        e.addr = {in.alu[31:2], 2'b00};
        e.be = 4'b1111;
        e.wdata = 32'h0;
        if (e.isMem && in.mw) begin
            e.be = 4'b0000;
            for (int i = 0; i < n; i++) begin
                modelMem[base + i] = in.wd[8*i +: 8];
                e.be[(base + i) % 4] = 1'b1;
            end
            e.wdata = (n == 1) ? {4{in.wd[7:0]}} : (n == 2) ? {2{in.wd[15:0]}} : in.wd;
        end
        if (e.isMem && in.mr) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(modelMem[base + i]) << (8 * i));
            if (n < 4) begin
                mask = (32'd1 << (8 * n)) - 32'd1;
                if (in.sg && v[8*n-1]) v = v | ~mask;
            end
            lastRead = v;
        end
        e.rdata = lastRead;
        e.stall = !mem ? 0 : (bad ? 1 : delay + 1);
        e.reqs  = e.isMem ? delay + 1 : 0;
        sbQ.push_back(e);
        if (e.isMem) delayQ.push_back(delay);
    endtask

    task automatic issue(input instr_t in, input int delay);
        bit s;
        int n;
        validE = in.valid;  aluOutE = in.alu;  writeDataE = in.wd;  writeRegAddrE = in.rd;
        regWriteE = in.rw;  memReadE = in.mr;  memWriteE = in.mw;  memSizeE = in.sz;
        memSignE = in.sg;
        n = 0;
        do begin
            @(negedge clk);
            s = stallM;
            @(posedge clk);
            n++;
        end while (s && n < 200);
        check("issue_timeout", 32'(s), 32'h0);
        modelCapture(in, delay);
        #1;
    endtask

    // Bus responder: per-transaction latency from delayQ, word memory updated through byte enables
    always @(negedge clk) begin
        if (dmem_req && !forceWait) begin
            if (remaining < 0) begin
                check("delay_queue_empty", 32'(delayQ.size() == 0), 32'h0);
                remaining = (delayQ.size() != 0) ? delayQ.pop_front() : 0;
            end
            if (remaining == 0) begin
                dmem_ready = 1'b1;
                if (dmem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (dmem_be[i]) busMem[dmem_addr[9:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
                end else begin
                    dmem_rdata = busMem[dmem_addr[9:2]];
                end
                remaining = -1;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
                remaining--;
            end
        end else begin
            dmem_ready = forceWait ? 1'b0 : 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end
    end

    // Monitor: head of sbQ is the instruction currently held in M; it retires on a cycle with stallM low
    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            if (sbQ.size() == 0) begin
                check("scoreboard_underflow", 32'(sbQ.size()), 32'h1);
            end else begin
                e = sbQ[0];
                if (stallM) begin
                    stallCnt++;
                    check("alignErr_while_stalled", 32'(alignErrM), 32'h0);
                end
                if (dmem_req) begin
                    reqCnt++;
                    if (!e.isMem) begin
                        check("spurious_req", 32'(dmem_req), 32'h0);
                    end else begin
                        check("bus_we", 32'(dmem_we), 32'(e.we));
                        check("bus_addr", dmem_addr, e.addr);
                        check("bus_be", 32'(dmem_be), 32'(e.be));
                        if (e.we) check("bus_wdata", dmem_wdata, e.wdata);
                    end
                end
                if (!stallM) begin
                    check("validM", 32'(validM), 32'(e.valid));
                    check("regWriteM", 32'(regWriteM), 32'(e.rw));
                    check("memToRegM", 32'(memToRegM), 32'(e.m2r));
                    check("readDataM", readDataM, e.rdata);
                    check("alignErrM", 32'(alignErrM), 32'(e.alignErr));
                    check("stall_cycles", 32'(stallCnt), 32'(e.stall));
                    check("req_cycles", 32'(reqCnt), 32'(e.reqs));
                    if (e.valid || e.full) begin
                        check("aluOutM", aluOutM, e.alu);
                        check("writeRegAddrM", 32'(writeRegAddrM), 32'(e.rd));
                    end
                    void'(sbQ.pop_front());
                    stallCnt = 0;
                    reqCnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", nChecks);
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        int   n;
        for (int i = 0; i < 1024; i++) modelMem[i] = 8'h00;
        for (int i = 0; i < 256; i++) busMem[i] = 32'h0;
        rst = 1'b1;  validE = 1'b0;  aluOutE = 32'h0;  writeDataE = 32'h0;  writeRegAddrE = 5'h0;
        regWriteE = 1'b0;  memReadE = 1'b0;  memWriteE = 1'b0;  memSizeE = 2'b00;  memSignE = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_stallM", 32'(stallM), 32'h0);
        check("rst_validM", 32'(validM), 32'h0);
        check("rst_alignErrM", 32'(alignErrM), 32'h0);
        check("rst_readDataM", readDataM, 32'h0);
        check("rst_aluOutM", aluOutM, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r.full = 1'b1;  r.valid = 1'b0;  r.rw = 1'b0;  r.m2r = 1'b0;  r.alignErr = 1'b0;
        r.isMem = 1'b0;  r.we = 1'b0;  r.alu = 32'h0;  r.rd = 5'h0;  r.rdata = 32'h0;
        r.addr = 32'h0;  r.wdata = 32'h0;  r.be = 4'h0;  r.stall = 0;  r.reqs = 0;
        sbQ.push_back(r);
        monOn = 1'b1;

        issue(mk(1'b1, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0), 0);
        issue(mk(1'b1, 32'h100, 32'h80123456, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0), 0);
        issue(mk(1'b1, 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1), 1);
        issue(mk(1'b1, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0), 0);
        issue(mk(1'b1, 32'h202, 32'h0000ABCD, 5'd6, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0), 3);
        issue(mk(1'b1, 32'h12345678, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 0);
        issue(mk(1'b1, 32'h200, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0), 2);
        issue(mk(1'b1, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0), 0);
        issue(mk(1'b0, 32'h104, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0), 0);
        issue(mk(1'b1, 32'h3FE, 32'h0000F00D, 5'd11, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0), 1);

        for (int i = 0; i < 400; i++) issue(randInstr(), int'($urandom_range(0, 3)));

        issue(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0), 0);
        n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(sbQ.size()), 32'h0);
        monOn = 1'b0;

        forceWait = 1'b1;
        #1;
        validE = 1'b1;  aluOutE = 32'h104;  writeRegAddrE = 5'd3;  regWriteE = 1'b1;
        memReadE = 1'b1;  memWriteE = 1'b0;  memSizeE = 2'b10;  memSignE = 1'b0;
        @(posedge clk);
        #1;
        validE = 1'b0;
        @(negedge clk);
        check("rstwait_req_idle", 32'(dmem_req), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstwait_req_wait", 32'(dmem_req), 32'h1);
        check("rstwait_stall_wait", 32'(stallM), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstwait_dmem_req", 32'(dmem_req), 32'h0);
        check("rstwait_stallM", 32'(stallM), 32'h0);
        check("rstwait_validM", 32'(validM), 32'h0);
        check("rstwait_regWriteM", 32'(regWriteM), 32'h0);
        check("rstwait_memToRegM", 32'(memToRegM), 32'h0);
        check("rstwait_aluOutM", aluOutM, 32'h0);
        check("rstwait_writeRegAddrM", 32'(writeRegAddrM), 32'h0);
        check("rstwait_readDataM", readDataM, 32'h0);
        check("rstwait_alignErrM", 32'(alignErrM), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstwait_req_stays_low", 32'(dmem_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. It holds the EX/MEM pipeline register, drives a valid/ready data-memory bus for loads and stores with byte/halfword lane handling, and feeds `aluOutM` back to the execute stage's forwarding muxes. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `validE`  in  1  execute stage holds a real instruction; 0 means bubble
- `aluOutE`  in  32  ALU result; this is the memory address for load/store
- `writeDataE`  in  32  forwarded store data
- `writeRegAddrE`  in  5  destination register
- `regWriteE`  in  1  instruction writes the register file
- `memReadE` / `memWriteE`  in  1 each  load / store; never both high
- `memSizeE`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `memSignE`  in  1  sign-extend loaded byte/half (1) or zero-extend (0)
- `aluOutM`  out  32  registered ALU result; forwarding source for the execute stage
- `writeRegAddrM`  out  5  registered destination
- `regWriteM`  out  1  registered write enable, qualified by `validM` and alignment
- `validM`  out  1  M register holds a real instruction
- `memToRegM`  out  1  registered `memReadE`
- `readDataM`  out  32  extended load data; valid in DONE
- `stallM`  out  1  hold PC, IF/ID and ID/EX
- `alignErrM`  out  1  misaligned access flag
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word address, `{aluOutM[31:2],2'b00}`
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables; bit i = bits [8i+7:8i]
- `dmem_ready`  in  1  bus accepts/completes the request this cycle
- `dmem_rdata`  in  32  read data, valid when `dmem_ready` is high on a read

## Operation

- EX/MEM register loads all `*E` inputs on each edge with `stallM`=0. It holds while `stallM`=1. When `validE`=0, it loads a bubble with valid, regWrite, memRead and memWrite all 0.
- The FSM is held in `state`, which is IDLE, WAIT or DONE. `memOpM` = `validM & (memReadM | memWriteM)`.
  - IDLE, `memOpM`=0: `stallM`=0, `dmem_req`=0.
  - IDLE, `memOpM`=1: `dmem_req`=1 and `stallM`=1. If `dmem_ready`, go to DONE; otherwise go to WAIT.
  - WAIT: `dmem_req`=1 and `stallM`=1. On `dmem_ready`, go to DONE.
  - DONE: `dmem_req`=0 and `stallM`=0. The M register advances and `state` returns to IDLE.
- On the edge where `dmem_ready`=1 during a read, the extracted and extended data is latched into `readDataM`.
- While `dmem_req`=1, `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_be` remain stable, because they derive only from the held M register.
- Store lanes:
  - Byte: `wdata={4{wd[7:0]}}`, `be=4'b0001<<addr[1:0]`.
  - Half: `wdata={2{wd[15:0]}}`, `be = addr[1] ? 1100 : 0011`.
  - Word: `be=1111`.
- Load extraction:
  - Byte: lane `addr[1:0]`.
  - Half: lane `addr[1]`.
  - Word: full 32 bits.
  - Byte and half results are extended to 32 bits per `memSignM`.
- `dmem_be` is 1111 on reads.

## Timing

- Reset values: all M register outputs 0, `readDataM`=0, `state`=IDLE, `dmem_req`=0, `stallM`=0, `alignErrM`=0.
- Non-memory instruction: occupies M for one cycle; `aluOutM` is valid the cycle after capture.
- Memory instruction: M occupancy is 2 cycles minimum when `dmem_ready` is high on the first request cycle. Each cycle that `dmem_ready` stays low adds one cycle.
- `stallM` is combinational from `state` and `memOpM` only, never from `dmem_ready`. This avoids a bus-to-pipeline combinational path.
- `rst` during WAIT: `state` goes to IDLE and the M register clears at that edge. `dmem_req` is low the next cycle, and the abandoned transaction is dropped.
- `dmem_ready` high while `dmem_req`=0 is ignored.
- Back-to-back memory ops: a new request starts in the IDLE cycle right after DONE.

## Configuration

- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned access is a half with `addr[0]`=1 or a word with `addr[1:0]`≠0.
  - It issues no bus request: `state` goes from IDLE directly to DONE.
  - `alignErrM`=1 during that DONE cycle.
  - `regWriteM` is forced to 0 and `readDataM` is unchanged.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `alignErrM` is tied to 0.
  - Low address bits outside the access size are ignored: a word uses lane 0–3 and a half uses `addr[1]`.
  - The access proceeds normally.

## Test plan

- Word store to 0x100 with data 0xDEADBEEF, `dmem_ready` tied 1 → one request cycle with `be`=1111 and `addr`=0x100; `stallM` is high for 1 cycle.
- Signed byte load at 0x103 with `rdata`=0x80123456 → `readDataM`=0xFFFFFF80. The same load with `memSignE`=0 gives 0x00000080.
- Half store 0xABCD to 0x202 with `dmem_ready` low for 3 cycles → `wdata`=0xABCDABCD and `be`=1100, with request signals held stable for 4 cycles; `stallM` is high for 4 cycles, then DONE.
- ALU op immediately followed by a load → the ALU op passes in 1 cycle with `aluOutM` equal to the ALU result; the load then stalls.
- Assert `rst` in WAIT → `dmem_req`=0, `state`=IDLE and all outputs are 0 the next cycle.
- With `MEM_ALIGN_CHECK_EN`, a word load at 0x101 → no `dmem_req`, `alignErrM`=1 for 1 cycle, `regWriteM`=0.
